// File: rtl/pipeline_pkg.sv
// Shared IF-stage types: FSM encoding, NOP, default HALT word, PC step.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } if_state_e;

   localparam logic [31:0] NOP         = 32'h0000_0000;
   localparam logic [31:0] HALT_OP_DEF = 32'hFFFF_FFFF;
   localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Debug/hazard/ID controls into IF and the IF/ID latch outputs.
interface instruction_fetch_if #(
   parameter int ADDR_W = 10
);
   logic              i_enable;
   logic              is_write_pc;
   logic              is_jump_taken;
   logic [31:0]       i_jump_addr;
   logic              i_load_we;
   logic [ADDR_W-1:0] i_load_addr;
   logic [31:0]       i_load_data;
   logic              i_start;
   logic [31:0]       o_pc;
   logic [31:0]       o_instruction;
   logic [1:0]        o_state;
   logic              o_halted;

   modport master (
      output i_enable, is_write_pc, is_jump_taken, i_jump_addr,
      output i_load_we, i_load_addr, i_load_data, i_start,
      input  o_pc, o_instruction, o_state, o_halted
   );

   modport slave (
      input  i_enable, is_write_pc, is_jump_taken, i_jump_addr,
      input  i_load_we, i_load_addr, i_load_data, i_start,
      output o_pc, o_instruction, o_state, o_halted
   );
endinterface

// File: rtl/instr_mem.sv
// Instruction memory: async read, sync write, no reset (contents survive rst).
module instr_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);
   logic [31:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, program download and LOAD/RUN/HALTED FSM.
// Build option IF_HALT_DETECT_EN enables HALT detection.
module instruction_fetch
   import pipeline_pkg::*;
#(
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] HALT_OPCODE = HALT_OP_DEF
) (
   input  logic              clk,
   input  logic              rst,
   instruction_fetch_if.slave bus
);
`ifdef IF_HALT_DETECT_EN
   localparam bit HALT_DET = 1'b1;
`else
   localparam bit HALT_DET = 1'b0;
`endif

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_inc, rdata;
   logic [31:0] out_pc, out_instr;
   logic        halt_hit, mem_we;

   assign pc_inc   = pc_q + PC_STEP;
   assign mem_we   = bus.i_load_we & (state_q == ST_LOAD);
   assign halt_hit = HALT_DET && (rdata == HALT_OPCODE);

   instr_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.i_load_addr),
      .wdata (bus.i_load_data),
      .raddr (pc_q[ADDR_W+1:2]),
      .rdata (rdata)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      out_pc    = NOP;
      out_instr = NOP;
      unique case (1'b1)
         state_q == ST_LOAD: begin
            pc_d = '0;
            if (bus.i_enable && bus.i_start) state_d = ST_RUN;
         end
         state_q == ST_RUN: begin
            out_pc    = pc_inc;
            out_instr = rdata;
            // a jump squashes the path holding a HALT
            if (bus.i_enable) begin
               if (bus.is_jump_taken)
                  pc_d = bus.i_jump_addr & ~32'd3;
               else if (halt_hit)
                  state_d = ST_HALTED;
               else if (bus.is_write_pc)
                  pc_d = pc_inc;
            end
         end
         default: begin
            out_pc = pc_inc;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_LOAD;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.o_pc          = out_pc;
   assign bus.o_instruction = out_instr;
   assign bus.o_state       = state_q;
`ifdef IF_HALT_DETECT_EN
   assign bus.o_halted      = (state_q == ST_HALTED);
`else
   assign bus.o_halted      = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Random + directed bench for instruction_fetch against a behavioural model.
module tb_instruction_fetch;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'h1111_0001;
  localparam logic [31:0] WB = 32'h2222_0002;
  localparam logic [31:0] WC = 32'h3333_0003;
  localparam logic [31:0] WD = 32'h4444_0004;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(AW)) bus();

  instruction_fetch #(.ADDR_W(AW), .HALT_OPCODE(HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m [DEPTH];
  logic [31:0] mpc;
  int          mst;
  logic [31:0] obs_pc, obs_ins, obs_st, obs_h;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [AW-1:0] idx;
    idx = a[AW+1:2];
    return m[idx];
  endfunction

  // next model state from the current inputs, applied at the clock edge
  task automatic model_step();
    if (mst == 0 && bus.i_load_we) m[bus.i_load_addr] = bus.i_load_data;
    if (!rst) begin
      mst = 0;
      mpc = 0;
    end else if (bus.i_enable) begin
      if (mst == 0) begin
        if (bus.i_start) mst = 1;
      end else if (mst == 1) begin
        if (bus.is_jump_taken)
          mpc = {bus.i_jump_addr[31:2], 2'b00};
        else if (HALT_EN && word_at(mpc) == HALT)
          mst = 2;
        else if (bus.is_write_pc)
          mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    obs_pc  = bus.o_pc;
    obs_ins = bus.o_instruction;
    obs_st  = 32'(bus.o_state);
    obs_h   = 32'(bus.o_halted);
    check("o_pc", obs_pc, mst == 0 ? 32'd0 : mpc + 32'd4);
    check("o_instruction", obs_ins, mst == 1 ? word_at(mpc) : 32'd0);
    check("o_state", obs_st, 32'(mst));
    check("o_halted", obs_h, 32'(mst == 2));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1;
    bus.i_enable = 1'b1;
    bus.is_write_pc = 1'b1;
    bus.is_jump_taken = 1'b0;
    bus.i_jump_addr = '0;
    bus.i_load_we = 1'b0;
    bus.i_load_addr = '0;
    bus.i_load_data = '0;
    bus.i_start = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] ins,
                              input logic [31:0] pc);
    cycle();
    check({tag, "_ins"}, obs_ins, ins);
    check({tag, "_pc"}, obs_pc, pc);
  endtask

  initial begin
    logic [31:0] d, held;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mst = 0;
    mpc = 0;
    cycle();
    check("rst_pc", obs_pc, 32'd0);
    check("rst_state", obs_st, 32'd0);

    // download program; last word lands together with i_start
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      if (d == HALT) d = 32'd0;
      if (i == 0) d = WA;
      if (i == 1) d = WB;
      if (i == 2) d = WC;
      if (i == 3) d = WD;
      bus.i_load_we = 1'b1;
      bus.i_load_addr = AW'(i);
      bus.i_load_data = d;
      bus.i_start = (i == DEPTH - 1);
      cycle();
    end
    idle();
    expect_fetch("t1a", WA, 32'd4);
    expect_fetch("t1b", WB, 32'd8);
    bus.is_write_pc = 1'b0;
    expect_fetch("t2s0", WC, 32'd12);
    expect_fetch("t2s1", WC, 32'd12);
    bus.is_write_pc = 1'b1;
    expect_fetch("t2s2", WC, 32'd12);
    expect_fetch("t2d", WD, 32'd16);

    bus.is_jump_taken = 1'b1;
    bus.is_write_pc = 1'b0;
    bus.i_jump_addr = 32'h0000_0040;
    cycle();
    idle();
    cycle();
    check("t3_jump_pc", obs_pc, 32'h44);
    bus.is_jump_taken = 1'b1;
    bus.i_jump_addr = 32'hFFFF_FFFF;
    cycle();
    idle();
    expect_fetch("t3_top", word_at(32'hFFFF_FFFC), 32'd0);
    expect_fetch("t3_wrap", WA, 32'd4);

    // writes in RUN are dropped
    bus.i_load_we = 1'b1;
    bus.i_load_addr = '0;
    bus.i_load_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    idle();
    bus.i_load_we = 1'b1;
    bus.i_load_addr = AW'(2);
    bus.i_load_data = HALT;
    bus.i_start = 1'b1;
    cycle();
    idle();
    expect_fetch("t4_a", WA, 32'd4);
    expect_fetch("t5_b", WB, 32'd8);
    expect_fetch("t5_halt", HALT, 32'd12);
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (HALT_EN) begin
        check("t5_nop", obs_ins, 32'd0);
        check("t5_halted", obs_h, 32'd1);
        check("t5_state", obs_st, 32'd2);
        check("t5_pc", obs_pc, 32'd12);
      end else begin
        check("t5_run", obs_st, 32'd1);
      end
    end

    // jump with HALT in the fetch slot: jump wins
    rst = 1'b0;
    cycle();
    idle();
    bus.i_start = 1'b1;
    cycle();
    idle();
    cycle();
    cycle();
    bus.is_jump_taken = 1'b1;
    bus.i_jump_addr = 32'h20;
    expect_fetch("t5_jh", HALT, 32'd12);
    idle();
    cycle();
    check("t5_jh_pc", obs_pc, 32'h24);
    check("t5_jh_st", obs_st, 32'd1);

    bus.i_enable = 1'b0;
    cycle();
    held = obs_pc;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t6_frozen", obs_pc, held);
    end
    idle();
    rst = 1'b0;
    cycle();
    idle();
    cycle();
    check("t6_pc", obs_pc, 32'd0);
    check("t6_ins", obs_ins, 32'd0);
    check("t6_st", obs_st, 32'd0);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom % 64) != 0;
      bus.i_enable = ($urandom % 8) != 0;
      bus.is_write_pc = ($urandom % 4) != 0;
      bus.is_jump_taken = ($urandom % 8) == 0;
      bus.i_jump_addr = ($urandom % 2) ? $urandom : ($urandom % 64);
      bus.i_load_we = ($urandom % 4) == 0;
      bus.i_load_addr = AW'($urandom);
      bus.i_load_data = $urandom;
      bus.i_start = ($urandom % 8) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
